// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for a combinational 1-bit ALU slice: latches operands,
// feeds one bit pair per clock LSB-first, and assembles the parallel result.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic [2:0]       M,
    output logic             A,
    output logic             B,
    output logic             CI,
    input  logic             X,
    input  logic             CO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       m_q, m_d;
    logic             ci_q, ci_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        ci_d    = ci_q;
        cout_d  = cout_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (START) begin
                    if (OP <= 3'd4) begin
                        opa_d   = OPA;
                        opb_d   = OPB;
                        m_d     = OP;
                        ci_d    = (OP == 3'd0) ? CIN : 1'b0;
                        cnt_d   = '0;
                        res_d   = '0;
                        cout_d  = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Slice outputs enter at the MSB so the first bit ends up at bit 0.
                res_d = {X, res_q[WIDTH-1:1]};
                ci_d  = (m_q == 3'd0) ? CO : 1'b0;
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    cout_d  = (m_q == 3'd0) ? CO : 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            m_q     <= 3'd0;
            ci_q    <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            ci_q    <= ci_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Every output decodes registered state only; X/CO never reach a port combinationally.
    assign BUSY   = (state_q == S_RUN);
    assign DONE   = (state_q == S_DONE);
    assign ERR    = err_q;
    assign RESULT = res_q;
    assign COUT   = cout_q;
    assign M      = m_q;
    assign A      = BUSY & opa_q[0];
    assign B      = BUSY & opb_q[0];
    assign CI     = ci_q;

endmodule
